servant_uart_rx: RTL

//  UART receiver for the servant SoC serial output q (bit-banged 8N1 console, LSB first).

---
 rtl/servant_uart_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant SoC console line, with a valid/ready holding register
// and one-cycle framing/overrun error pulses.
module servant_uart_rx #(
    parameter int BAUD_DIV = 278
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [2:0] o_state
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    idx;
    logic [2:0]    idx_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          tick;
    logic          byte_done;
    logic          frame_bad;

    assign tick    = (cnt == '0);
    assign o_state = state;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        shreg_nx  = shreg;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if ((state == START || state == DATA || state == STOP) && !tick) begin
            cnt_nx = cnt - 1'b1;
        end
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = CNT_HALF;
                end
            end
            START: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (tick) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        cnt_nx   = CNT_BIT;
                        idx_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nx = {rx_s, shreg[7:1]};
                    idx_nx   = idx + 3'd1;
                    cnt_nx   = CNT_BIT;
                    if (idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so an immediately following start bit is caught.
                if (tick) begin
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nx  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake: a byte transfers on any cycle with o_valid & i_ready; o_data holds while
    // o_valid=1 and i_ready=0, and i_ready is ignored while o_valid=0.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_bad;
            o_overrun   <= 1'b0;
            if (o_valid && i_ready) o_valid <= 1'b0;
            if (byte_done) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule
